// File: rtl/switch_debounce_pkg.sv
// Shared constants for the switch debounce/capture block: register map and bus width.
package switch_debounce_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK  = 2'd1;
  localparam logic [1:0] ADDR_LAST_EDGE = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP  = 2'd3;

  // Zero-extend a WIDTH-bit field onto the 32-bit readback bus.
  function automatic logic [DATA_W-1:0] zext(input logic [DATA_W-1:0] v, input int w);
    logic [DATA_W-1:0] m;
    m = (w >= DATA_W) ? '1 : ((DATA_W'(1) << w) - DATA_W'(1));
    return v & m;
  endfunction

endpackage

// File: rtl/switch_debounce_capture_debounce_bit.sv
// One switch input: 2-flop synchronizer, hold-time counter and accepted (stable) level.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic pin,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic meta;
  logic sync;
  logic [CW-1:0] cnt;

  // Any sample matching the accepted level restarts the hold window, so glitches never reach stable.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debounce_capture.sv
// Debounced switch input port with edge capture, IRQ mask and Avalon-MM slave (read latency 1).
// Build option SWITCH_DEBOUNCE_FALL_EDGE_EN: capture both edges and expose LAST_EDGE at address 2.
module switch_debounce_capture
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [WIDTH-1:0]  sw_in,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              irq,
  output logic [WIDTH-1:0]  sw_stable
);

  logic [WIDTH-1:0]  stable_d;
  logic [WIDTH-1:0]  edge_cap;
  logic [WIDTH-1:0]  irq_mask;
  logic [WIDTH-1:0]  edge_set;
  logic [WIDTH-1:0]  cap_clr;
  logic              mask_we;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .pin           (sw_in[gi]),
        .stable        (sw_stable[gi])
      );
    end
  endgenerate

`ifdef SWITCH_DEBOUNCE_FALL_EDGE_EN
  logic [WIDTH-1:0] last_edge;
  assign edge_set = sw_stable ^ stable_d;
`else
  assign edge_set = sw_stable & ~stable_d;
`endif

  assign cap_clr = (avs_write && avs_address == ADDR_EDGE_CAP) ? avs_writedata[WIDTH-1:0] : '0;
  assign mask_we = avs_write && (avs_address == ADDR_IRQ_MASK);
  assign unused_wdata = &{1'b0, avs_writedata};

  // Set is OR'd in after the clear so a same-cycle edge is never lost.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_d <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      stable_d <= sw_stable;
      edge_cap <= (edge_cap & ~cap_clr) | edge_set;
      if (mask_we) irq_mask <= avs_writedata[WIDTH-1:0];
      irq <= |(edge_cap & irq_mask);
    end
  end

`ifdef SWITCH_DEBOUNCE_FALL_EDGE_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      last_edge <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (edge_set[i]) last_edge[i] <= sw_stable[i];
      end
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:      rd_mux = zext(DATA_W'(sw_stable), WIDTH);
      ADDR_IRQ_MASK:  rd_mux = zext(DATA_W'(irq_mask), WIDTH);
`ifdef SWITCH_DEBOUNCE_FALL_EDGE_EN
      ADDR_LAST_EDGE: rd_mux = zext(DATA_W'(last_edge), WIDTH);
`else
      ADDR_LAST_EDGE: rd_mux = '0;
`endif
      ADDR_EDGE_CAP:  rd_mux = zext(DATA_W'(edge_cap), WIDTH);
      default:        rd_mux = '0;
    endcase
  end

  // Mux samples pre-write state, so a read paired with a write sees the old value.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs_readdata <= '0;
    else if (avs_read)  avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_switch_debounce_capture.sv
// Scenario bench for switch_debounce_capture (WIDTH=4, DEBOUNCE_CYCLES=8); read results via a scoreboard queue.
module tb_switch_debounce_capture;

  localparam int W = 4;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  sw_in = '0;
  logic [1:0]    addr = '0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          irq;
  logic [W-1:0]  sw_stable;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  switch_debounce_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sw_in         (sw_in),
    .avs_address   (addr),
    .avs_read      (rd),
    .avs_write     (wr),
    .avs_writedata (wdata),
    .avs_readdata  (rdata),
    .irq           (irq),
    .sw_stable     (sw_stable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic rd_check(input logic [1:0] a, input logic [31:0] expv, input string name);
    logic [31:0] got, want;
    exp_q.push_back(expv);
    bus_rd(a, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({sw_stable, irq, rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got st=%h irq=%b rd=%h want all 0", sw_stable, irq, rdata);
    end
    rst_n = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if (sw_stable !== '0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got st=%h irq=%b want 0 0", sw_stable, irq);
    end
    rd_check(2'd0, 32'h0, "data_idle");
    rd_check(2'd1, 32'h0, "mask_reset");
    rd_check(2'd2, 32'h0, "addr2_reset");
    rd_check(2'd3, 32'h0, "edgecap_reset");
  endtask

  task automatic test_step();
    sw_in[0] = 1'b1;
    for (int i = 1; i <= D + 2; i++) begin
      tick();
      if (i == D + 1 || i == D + 2) begin
        n_cmp++;
        if (sw_stable[0] !== (i == D + 2)) begin
          n_err++;
          $display("FAIL step_latency_%0d: got %b want %b", i, sw_stable[0], (i == D + 2));
        end
      end
    end
    tick();
    rd_check(2'd3, 32'h1, "step_edgecap");
    rd_check(2'd0, 32'h1, "step_data");
  endtask

  task automatic test_bounce();
    bit moved = 0;
    bus_wr(2'd3, 32'hF);
    for (int k = 0; k < 14; k++) begin
      sw_in[1] = ~sw_in[1];
      repeat (3) begin
        tick();
        if (sw_stable[1] !== 1'b0) moved = 1;
      end
    end
    n_cmp++;
    if (moved) begin
      n_err++;
      $display("FAIL bounce_hold: got stable change during bounce want none");
    end
    sw_in[1] = 1'b1;
    repeat (D + 1) tick();
    n_cmp++;
    if (sw_stable[1] !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_early: got %b want 0", sw_stable[1]);
    end
    tick();
    n_cmp++;
    if (sw_stable[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_accept: got %b want 1", sw_stable[1]);
    end
    tick();
    rd_check(2'd3, 32'h2, "bounce_edgecap");
  endtask

  task automatic test_irq();
    logic [31:0] got, want;
    bus_wr(2'd3, 32'hF);
    bus_wr(2'd1, 32'h4);
    // Read and write in the same cycle returns the old mask.
    exp_q.push_back(32'h4);
    addr = 2'd1; rd = 1'b1; wr = 1'b1; wdata = 32'hFFFF_FFF5;
    tick();
    rd = 1'b0; wr = 1'b0;
    want = exp_q.pop_front();
    n_cmp++;
    if (rdata !== want) begin
      n_err++;
      $display("FAIL rw_same_cycle: got 0x%08h want 0x%08h", rdata, want);
    end
    rd_check(2'd1, 32'h5, "mask_upper_zero");
    tick();
    n_cmp++;
    if (rdata !== 32'h5) begin
      n_err++;
      $display("FAIL readdata_hold: got 0x%08h want 0x00000005", rdata);
    end
    bus_wr(2'd1, 32'h4);
    sw_in[2] = 1'b1;
    for (int i = 1; i <= D + 4; i++) begin
      tick();
      if (i >= D + 2) begin
        n_cmp++;
        if (irq !== (i >= D + 4)) begin
          n_err++;
          $display("FAIL irq_rise_%0d: got %b want %b", i, irq, (i >= D + 4));
        end
      end
    end
    bus_wr(2'd3, 32'h4);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_clear_lag: got %b want 1", irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_cleared: got %b want 0", irq);
    end
    rd_check(2'd3, 32'h0, "irq_edgecap_clear");
    bus_wr(2'd0, 32'hF);
    rd_check(2'd0, 32'h7, "data_ro");
  endtask

  task automatic test_collision();
    bus_wr(2'd3, 32'hF);
    sw_in[3] = 1'b1;
    repeat (D + 2) tick();
    // rise[3] is high now; the W1C lands on the same edge that sets the bit.
    bus_wr(2'd3, 32'h8);
    rd_check(2'd3, 32'h8, "collision_set_wins");
    bus_wr(2'd3, 32'h8);
    rd_check(2'd3, 32'h0, "w1c_clears");
  endtask

  task automatic test_fall_edge();
    sw_in[0] = 1'b0;
    repeat (D + 4) tick();
    n_cmp++;
    if (sw_stable !== 4'hE) begin
      n_err++;
      $display("FAIL fall_data: got %h want e", sw_stable);
    end
`ifdef SWITCH_DEBOUNCE_FALL_EDGE_EN
    rd_check(2'd3, 32'h1, "fall_edgecap");
    rd_check(2'd2, 32'hE, "last_edge");
`else
    rd_check(2'd3, 32'h0, "fall_edgecap");
    rd_check(2'd2, 32'h0, "addr2_reserved");
`endif
  endtask

  task automatic test_mid_reset();
    sw_in = '0;
    repeat (D + 4) tick();
    rd_check(2'd1, 32'h4, "pre_reset_mask");
    sw_in = 4'hF;
    repeat (7) tick();
    n_cmp++;
    if (sw_stable !== 4'h0) begin
      n_err++;
      $display("FAIL mid_count_stable: got %h want 0", sw_stable);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sw_stable !== '0 || irq !== 1'b0 || rdata !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got st=%h irq=%b rd=%h want 0", sw_stable, irq, rdata);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= D + 2; i++) begin
      tick();
      if (i >= D + 1) begin
        n_cmp++;
        if (sw_stable !== ((i == D + 2) ? 4'hF : 4'h0)) begin
          n_err++;
          $display("FAIL restart_%0d: got %h want %h", i, sw_stable, ((i == D + 2) ? 4'hF : 4'h0));
        end
      end
    end
    tick();
    rd_check(2'd3, 32'hF, "restart_edgecap");
    rd_check(2'd1, 32'h0, "restart_mask");
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL restart_irq: got %b want 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_bounce();
    test_irq();
    test_collision();
    test_fall_edge();
    test_mid_reset();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
